// File: rtl/ahbl_uart_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_uart_slave_if
// Brief    : AHB-lite bus bundle between the system decoder and the UART slave.
// Revision : 1.0 - initial release
// ============================================================================
interface ahbl_uart_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRDATA
    );
endinterface
`default_nettype wire

// File: rtl/ahbl_uart_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_uart_slave
// Brief    : Zero-wait-state AHB-lite UART (8N1) with TX/RX FIFOs and level IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module ahbl_uart_slave #(
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd103
) (
    input  wire              HCLK,
    input  wire              HRESETn,
    ahbl_uart_slave_if.slave bus,
    input  wire              RX,
    output logic             TX,
    output logic             IRQ
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

    logic        dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
    logic [1:0]  dp_addr_q, dp_addr_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic        ovr_q, ovr_d, fe_q, fe_d, irq_q, irq_d;

    logic [7:0]  tx_mem_q [FIFO_DEPTH];
    logic [7:0]  rx_mem_q [FIFO_DEPTH];
    logic [AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;

    state_t      tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic        tx_q, tx_d;
    logic [2:0]  rx_sync_q, rx_sync_d;

    logic        w_wr_data, w_wr_stat, w_wr_pres, w_wr_ctrl, w_rd_data;
    logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic        w_tx_push, w_tx_pop, w_rx_push_req, w_rx_push, w_rx_pop;
    logic        w_rx_ovr_set, w_rx_fe_set, w_tx_busy, w_rx_bit, w_rx_fall;
    logic [7:0]  w_tx_head, w_rx_head;
    logic [16:0] w_half;
    logic [15:0] w_half_cnt;
    logic [31:0] w_status, w_rdata;
    logic        unused_bits;

    assign unused_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HSIZE, bus.HWDATA[31:16]};

    assign w_wr_data = dp_valid_q &  dp_write_q & (dp_addr_q == 2'd0);
    assign w_wr_stat = dp_valid_q &  dp_write_q & (dp_addr_q == 2'd1);
    assign w_wr_pres = dp_valid_q &  dp_write_q & (dp_addr_q == 2'd2);
    assign w_wr_ctrl = dp_valid_q &  dp_write_q & (dp_addr_q == 2'd3);
    assign w_rd_data = dp_valid_q & ~dp_write_q & (dp_addr_q == 2'd0);

    // Extra MSB on each pointer separates full (MSBs differ) from empty.
    assign w_tx_empty = (tx_wp_q == tx_rp_q);
    assign w_tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign w_rx_empty = (rx_wp_q == rx_rp_q);
    assign w_rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign w_tx_head  = tx_mem_q[tx_rp_q[AW-1:0]];
    assign w_rx_head  = rx_mem_q[rx_rp_q[AW-1:0]];

    assign w_tx_push    = w_wr_data & (~w_tx_full | w_tx_pop);
    assign w_rx_pop     = w_rd_data & ~w_rx_empty;
    assign w_rx_push    = w_rx_push_req & (~w_rx_full | w_rx_pop);
    assign w_rx_ovr_set = w_rx_push_req & w_rx_full & ~w_rx_pop;

    assign w_tx_busy  = (tx_state_q != S_IDLE);
    assign w_rx_bit   = rx_sync_q[1];
    assign w_rx_fall  = rx_sync_q[2] & ~rx_sync_q[1];
    assign w_half     = ({1'b0, prescale_q} + 17'd1) >> 1;
    assign w_half_cnt = (w_half == 17'd0) ? 16'd0 : 16'(w_half - 17'd1);

    assign w_status = {25'd0, w_tx_busy, fe_q, ovr_q, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    always_comb begin
        w_rdata = 32'd0;
        if (dp_valid_q && !dp_write_q) begin
            case (dp_addr_q)
                2'd0:    w_rdata = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
                2'd1:    w_rdata = w_status;
                2'd2:    w_rdata = {16'd0, prescale_q};
                default: w_rdata = {28'd0, ctrl_q};
            endcase
        end
    end

    assign bus.HRDATA    = w_rdata;
    assign bus.HREADYOUT = 1'b1;
    assign TX            = tx_q;
    assign IRQ           = irq_q;

    always_comb begin
        dp_valid_d = bus.HSEL & bus.HREADY & bus.HTRANS[1];
        dp_write_d = bus.HWRITE;
        dp_addr_d  = bus.HADDR[3:2];
        ctrl_d     = w_wr_ctrl ? bus.HWDATA[3:0]  : ctrl_q;
        prescale_d = w_wr_pres ? bus.HWDATA[15:0] : prescale_q;
        ovr_d      = (ovr_q & ~(w_wr_stat & bus.HWDATA[4])) | w_rx_ovr_set;
        fe_d       = (fe_q  & ~(w_wr_stat & bus.HWDATA[5])) | w_rx_fe_set;
        irq_d      = (ctrl_q[2] & ~w_rx_empty) | (ctrl_q[3] & w_tx_empty);
        tx_wp_d    = tx_wp_q + {{AW{1'b0}}, w_tx_push};
        tx_rp_d    = tx_rp_q + {{AW{1'b0}}, w_tx_pop};
        rx_wp_d    = rx_wp_q + {{AW{1'b0}}, w_rx_push};
        rx_rp_d    = rx_rp_q + {{AW{1'b0}}, w_rx_pop};
        rx_sync_d  = {rx_sync_q[1:0], RX};
    end

    // A pop in STOP chains straight into the next START with no idle bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        w_tx_pop   = 1'b0;
        case (tx_state_q)
            S_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = prescale_q;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_sh_q[0];
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = prescale_q;
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_d     = tx_sh_q[1];
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else if (ctrl_q[0] && !w_tx_empty) begin
                    w_tx_pop   = 1'b1;
                    tx_sh_d    = w_tx_head;
                    tx_cnt_d   = prescale_q;
                    tx_d       = 1'b0;
                    tx_state_d = S_START;
                end else begin
                    tx_d       = 1'b1;
                    tx_state_d = S_IDLE;
                end
            end
            default: begin
                tx_d = 1'b1;
                if (ctrl_q[0] && !w_tx_empty) begin
                    w_tx_pop   = 1'b1;
                    tx_sh_d    = w_tx_head;
                    tx_cnt_d   = prescale_q;
                    tx_d       = 1'b0;
                    tx_state_d = S_START;
                end
            end
        endcase
    end

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_sh_d       = rx_sh_q;
        rx_bit_d      = rx_bit_q;
        w_rx_push_req = 1'b0;
        w_rx_fe_set   = 1'b0;
        case (rx_state_q)
            S_START: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else if (w_rx_bit) begin
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d   = prescale_q;
                    rx_bit_d   = 3'd0;
                    rx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else begin
                    rx_sh_d  = {w_rx_bit, rx_sh_q[7:1]};
                    rx_cnt_d = prescale_q;
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else begin
                    w_rx_push_req = w_rx_bit;
                    w_rx_fe_set   = ~w_rx_bit;
                    rx_state_d    = S_IDLE;
                end
            end
            default: begin
                if (ctrl_q[1] && w_rx_fall) begin
                    rx_cnt_d   = w_half_cnt;
                    rx_state_d = S_START;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (w_tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= bus.HWDATA[7:0];
        if (w_rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= rx_sh_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 2'd0;
            ctrl_q     <= 4'd0;
            prescale_q <= DEFAULT_PRESCALE;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            irq_q      <= 1'b0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_sh_q    <= 8'd0;
            tx_bit_q   <= 3'd0;
            tx_q       <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_sh_q    <= 8'd0;
            rx_bit_q   <= 3'd0;
            rx_sync_q  <= 3'b111;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            ovr_q      <= ovr_d;
            fe_q       <= fe_d;
            irq_q      <= irq_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            rx_sync_q  <= rx_sync_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ahbl_uart_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahbl_uart_slave
// Brief    : Directed self-checking bench for the AHB-lite UART slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahbl_uart_slave;
    logic HCLK;
    logic HRESETn;
    logic RX;
    logic TX;
    logic IRQ;
    int   n_checks = 0;
    int   n_pass   = 0;

    ahbl_uart_slave_if bus();

    ahbl_uart_slave #(
        .FIFO_DEPTH       (16),
        .DEFAULT_PRESCALE (16'd103)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus),
        .RX      (RX),
        .TX      (TX),
        .IRQ     (IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        bus.HSEL = 1'b1; bus.HADDR = a; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1;
        tick(1);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = d;
        tick(1);
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        bus.HSEL = 1'b1; bus.HADDR = a; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0;
        tick(1);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        d = bus.HRDATA;
        tick(1);
    endtask

    // Samples the middle of each bit of one frame at 10 cycles per bit; {stop, data}.
    task automatic recv_tx_byte(output logic [8:0] v, output bit got);
        int t = 0;
        got = 1'b0;
        v   = '0;
        while (TX !== 1'b0 && t < 400) begin
            tick(1);
            t++;
        end
        if (TX === 1'b0) begin
            got = 1'b1;
            tick(5);
            for (int i = 0; i < 8; i++) begin
                tick(10);
                v[i] = TX;
            end
            tick(10);
            v[8] = TX;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(10);
        end
        RX = stop;
        tick(10);
        RX = 1'b1;
        tick(20);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        n_checks++; if (TX !== 1'b1) $display("FAIL reset_tx: got %b expected 1", TX); else n_pass++;
        n_checks++; if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b expected 0", IRQ); else n_pass++;
        n_checks++; if (bus.HRDATA !== 32'd0) $display("FAIL reset_hrdata: got %h expected 0", bus.HRDATA); else n_pass++;
        n_checks++; if (bus.HREADYOUT !== 1'b1) $display("FAIL reset_hreadyout: got %b expected 1", bus.HREADYOUT); else n_pass++;
        HRESETn = 1'b1;
        tick(2);
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h0A) $display("FAIL reset_status: got %h expected %h", r, 32'h0A); else n_pass++;
        ahb_read(32'h8, r);
        n_checks++; if (r !== 32'd103) $display("FAIL reset_prescale: got %h expected %h", r, 32'd103); else n_pass++;
        ahb_read(32'hC, r);
        n_checks++; if (r !== 32'd0) $display("FAIL reset_ctrl: got %h expected 0", r); else n_pass++;
        ahb_read(32'h0, r);
        n_checks++; if (r !== 32'd0) $display("FAIL reset_data_empty: got %h expected 0", r); else n_pass++;
    endtask

    task automatic test_tx_frame();
        logic [31:0] r;
        logic [7:0]  b = 8'hA5;
        logic [99:0] cap;
        logic [99:0] exp;
        int          t = 0;
        ahb_write(32'h8, 32'd9);
        ahb_read(32'h8, r);
        n_checks++; if (r !== 32'd9) $display("FAIL prescale_rw: got %h expected 9", r); else n_pass++;
        ahb_write(32'hC, 32'h1);
        ahb_write(32'h0, {24'd0, b});
        while (TX !== 1'b0 && t < 300) begin
            tick(1);
            t++;
        end
        n_checks++; if (TX !== 1'b0) $display("FAIL tx_start: got %b expected 0 within 300 cycles", TX); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            exp[i] = (i < 10) ? 1'b0 : (i >= 90) ? 1'b1 : b[(i / 10) - 1];
            cap[i] = TX;
            tick(1);
        end
        n_checks++; if (cap !== exp) $display("FAIL tx_waveform_a5: got %h expected %h", cap, exp); else n_pass++;
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h0A) $display("FAIL tx_busy_clear: got %h expected %h", r, 32'h0A); else n_pass++;
    endtask

    task automatic test_tx_fifo_full();
        logic [31:0] r;
        logic [8:0]  v;
        bit          got;
        int          lows = 0;
        ahb_write(32'hC, 32'h0);
        for (int i = 0; i < 17; i++) ahb_write(32'h0, i);
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h09) $display("FAIL txfull_status: got %h expected %h", r, 32'h09); else n_pass++;
        ahb_write(32'hC, 32'h1);
        for (int i = 0; i < 16; i++) begin
            recv_tx_byte(v, got);
            n_checks++;
            if (!got || v !== {1'b1, 8'(i)}) $display("FAIL tx_fifo_frame%0d: got %h (seen %0d) expected %h", i, v, got, {1'b1, 8'(i)});
            else n_pass++;
        end
        for (int i = 0; i < 200; i++) begin
            if (TX !== 1'b1) lows++;
            tick(1);
        end
        n_checks++; if (lows !== 0) $display("FAIL tx_no_17th_frame: got %0d low cycles expected 0", lows); else n_pass++;
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h0A) $display("FAIL tx_drained_status: got %h expected %h", r, 32'h0A); else n_pass++;
    endtask

    task automatic test_rx_basic();
        logic [31:0] r;
        ahb_write(32'hC, 32'h6);
        send_rx(8'h3C, 1'b1);
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h02) $display("FAIL rx_status_ready: got %h expected %h", r, 32'h02); else n_pass++;
        n_checks++; if (IRQ !== 1'b1) $display("FAIL rx_irq_set: got %b expected 1", IRQ); else n_pass++;
        ahb_read(32'h0, r);
        n_checks++; if (r !== 32'h3C) $display("FAIL rx_data: got %h expected %h", r, 32'h3C); else n_pass++;
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h0A) $display("FAIL rx_status_popped: got %h expected %h", r, 32'h0A); else n_pass++;
        n_checks++; if (IRQ !== 1'b0) $display("FAIL rx_irq_clear: got %b expected 0", IRQ); else n_pass++;
    endtask

    task automatic test_rx_overrun();
        logic [31:0] r;
        ahb_write(32'hC, 32'h2);
        for (int i = 0; i < 17; i++) send_rx(8'(8'h40 + i), 1'b1);
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h16) $display("FAIL ovr_status: got %h expected %h", r, 32'h16); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            ahb_read(32'h0, r);
            n_checks++;
            if (r !== 32'(8'h40 + i)) $display("FAIL ovr_data%0d: got %h expected %h", i, r, 32'(8'h40 + i));
            else n_pass++;
        end
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h1A) $display("FAIL ovr_sticky: got %h expected %h", r, 32'h1A); else n_pass++;
        ahb_write(32'h4, 32'h10);
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h0A) $display("FAIL ovr_clear: got %h expected %h", r, 32'h0A); else n_pass++;
    endtask

    task automatic test_rx_errors();
        logic [31:0] r;
        send_rx(8'h55, 1'b0);
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h2A) $display("FAIL frame_err_status: got %h expected %h", r, 32'h2A); else n_pass++;
        ahb_write(32'h4, 32'h20);
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h0A) $display("FAIL frame_err_clear: got %h expected %h", r, 32'h0A); else n_pass++;
        RX = 1'b0;
        tick(3);
        RX = 1'b1;
        tick(150);
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h0A) $display("FAIL glitch_ignored: got %h expected %h", r, 32'h0A); else n_pass++;
        send_rx(8'h81, 1'b1);
        ahb_read(32'h0, r);
        n_checks++; if (r !== 32'h81) $display("FAIL rx_after_glitch: got %h expected %h", r, 32'h81); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        int          t = 0;
        ahb_write(32'hC, 32'h9);
        ahb_write(32'h0, 32'h00);
        while (TX !== 1'b0 && t < 300) begin
            tick(1);
            t++;
        end
        tick(30);
        n_checks++; if (TX !== 1'b0) $display("FAIL midframe_tx_low: got %b expected 0", TX); else n_pass++;
        n_checks++; if (IRQ !== 1'b1) $display("FAIL midframe_tx_irq: got %b expected 1", IRQ); else n_pass++;
        #3;
        HRESETn = 1'b0;
        #1;
        n_checks++; if (TX !== 1'b1) $display("FAIL async_reset_tx: got %b expected 1", TX); else n_pass++;
        n_checks++; if (IRQ !== 1'b0) $display("FAIL async_reset_irq: got %b expected 0", IRQ); else n_pass++;
        n_checks++; if (bus.HRDATA !== 32'd0) $display("FAIL async_reset_hrdata: got %h expected 0", bus.HRDATA); else n_pass++;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        tick(1);
        ahb_read(32'h4, r);
        n_checks++; if (r !== 32'h0A) $display("FAIL post_reset_status: got %h expected %h", r, 32'h0A); else n_pass++;
        ahb_read(32'h8, r);
        n_checks++; if (r !== 32'd103) $display("FAIL post_reset_prescale: got %h expected %h", r, 32'd103); else n_pass++;
        ahb_read(32'hC, r);
        n_checks++; if (r !== 32'd0) $display("FAIL post_reset_ctrl: got %h expected 0", r); else n_pass++;
        ahb_read(32'h0, r);
        n_checks++; if (r !== 32'd0) $display("FAIL post_reset_data: got %h expected 0", r); else n_pass++;
        n_checks++; if (TX !== 1'b1) $display("FAIL post_reset_tx_idle: got %b expected 1", TX); else n_pass++;
    endtask

    initial begin
        HRESETn     = 1'b0;
        RX          = 1'b1;
        bus.HSEL    = 1'b0;
        bus.HADDR   = 32'd0;
        bus.HTRANS  = 2'b00;
        bus.HWRITE  = 1'b0;
        bus.HSIZE   = 3'b010;
        bus.HWDATA  = 32'd0;
        bus.HREADY  = 1'b1;
        tick(3);
        test_reset();
        test_tx_frame();
        test_tx_fifo_full();
        test_rx_basic();
        test_rx_overrun();
        test_rx_errors();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
